// File: rtl/microwave_timer_ctrl.sv
// Microwave cook timer: BCD M:SS entry from a keypad, countdown on sec_tick,
// pause on door-open/stop, and a timed done indication.
module microwave_timer_ctrl #(
    parameter int DONE_TICKS = 3
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       keypad_valid,
    input  logic [3:0] keypad_digit,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       door_closed,
    input  logic       sec_tick,
    output logic [3:0] units_sec,
    output logic [3:0] tens_sec,
    output logic [3:0] minutes,
    output logic       magnetron_on,
    output logic       done
);

    localparam int CW = (DONE_TICKS < 2) ? 1 : $clog2(DONE_TICKS);
    localparam logic [CW-1:0] CNT_LAST = CW'(DONE_TICKS - 1);

    typedef enum logic [1:0] {IDLE, COOK, PAUSE, DONE} state_t;

    state_t        state, state_nxt;
    logic [3:0]    units_nxt, tens_nxt, minutes_nxt;
    logic [3:0]    units_dec, tens_dec, minutes_dec;
    logic [CW-1:0] done_cnt, cnt_nxt;
    logic          time_zero, last_sec;

    assign time_zero = (minutes == 4'd0) && (tens_sec == 4'd0) && (units_sec == 4'd0);
    assign last_sec  = (minutes == 4'd0) && (tens_sec == 4'd0) && (units_sec == 4'd1);

    // BCD countdown with borrow: units wrap 0->9, tens wrap 0->5
    always_comb begin
        units_dec   = units_sec - 4'd1;
        tens_dec    = tens_sec;
        minutes_dec = minutes;
        if (units_sec == 4'd0) begin
            units_dec = 4'd9;
            if (tens_sec == 4'd0) begin
                tens_dec    = 4'd5;
                minutes_dec = minutes - 4'd1;
            end else begin
                tens_dec = tens_sec - 4'd1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        units_nxt   = units_sec;
        tens_nxt    = tens_sec;
        minutes_nxt = minutes;
        cnt_nxt     = done_cnt;
        if (clear) begin
            state_nxt   = IDLE;
            units_nxt   = 4'd0;
            tens_nxt    = 4'd0;
            minutes_nxt = 4'd0;
            cnt_nxt     = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (stop) begin
                        units_nxt   = 4'd0;
                        tens_nxt    = 4'd0;
                        minutes_nxt = 4'd0;
                    end else if (start) begin
                        if (door_closed && !time_zero)
                            state_nxt = COOK;
                    end else if (keypad_valid && keypad_digit <= 4'd9 && units_sec <= 4'd5) begin
                        minutes_nxt = tens_sec;
                        tens_nxt    = units_sec;
                        units_nxt   = keypad_digit;
                    end
                end
                COOK: begin
                    if (stop || !door_closed) begin
                        state_nxt = PAUSE;
                    end else if (sec_tick) begin
                        units_nxt   = units_dec;
                        tens_nxt    = tens_dec;
                        minutes_nxt = minutes_dec;
                        if (last_sec) begin
                            state_nxt = DONE;
                            cnt_nxt   = '0;
                        end
                    end
                end
                PAUSE: begin
                    if (stop) begin
                        state_nxt   = IDLE;
                        units_nxt   = 4'd0;
                        tens_nxt    = 4'd0;
                        minutes_nxt = 4'd0;
                    end else if (start && door_closed) begin
                        state_nxt = COOK;
                    end
                end
                DONE: begin
                    if (stop || start) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else if (sec_tick) begin
                        if (done_cnt == CNT_LAST) begin
                            state_nxt = IDLE;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = done_cnt + 1'b1;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they change on the same edge
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            units_sec    <= 4'd0;
            tens_sec     <= 4'd0;
            minutes      <= 4'd0;
            done_cnt     <= '0;
            magnetron_on <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_nxt;
            units_sec    <= units_nxt;
            tens_sec     <= tens_nxt;
            minutes      <= minutes_nxt;
            done_cnt     <= cnt_nxt;
            magnetron_on <= (state_nxt == COOK);
            done         <= (state_nxt == DONE);
        end
    end

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Directed self-checking bench for microwave_timer_ctrl: entry, countdown,
// pause/resume, done timeout and asynchronous reset.
module tb_microwave_timer_ctrl;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       keypad_valid = 1'b0;
    logic [3:0] keypad_digit = 4'd0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       clear = 1'b0;
    logic       door_closed = 1'b1;
    logic       sec_tick = 1'b0;
    logic [3:0] units_sec, tens_sec, minutes;
    logic       magnetron_on, done;

    int compared = 0;
    int mismatched = 0;

    microwave_timer_ctrl #(.DONE_TICKS(3)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .keypad_valid (keypad_valid),
        .keypad_digit (keypad_digit),
        .start        (start),
        .stop         (stop),
        .clear        (clear),
        .door_closed  (door_closed),
        .sec_tick     (sec_tick),
        .units_sec    (units_sec),
        .tens_sec     (tens_sec),
        .minutes      (minutes),
        .magnetron_on (magnetron_on),
        .done         (done)
    );

    always #5 clock = ~clock;

    // Drive one cycle of strobes around a rising edge, then sample 1 ns after it
    task automatic applyStimulus(input logic kv, input logic [3:0] kd, input logic st,
                                 input logic sp, input logic cl, input logic tk);
        @(negedge clock);
        keypad_valid = kv;
        keypad_digit = kd;
        start        = st;
        stop         = sp;
        clear        = cl;
        sec_tick     = tk;
        @(posedge clock);
        #1;
        keypad_valid = 1'b0;
        keypad_digit = 4'd0;
        start        = 1'b0;
        stop         = 1'b0;
        clear        = 1'b0;
        sec_tick     = 1'b0;
    endtask

    task automatic key(input logic [3:0] d);
        applyStimulus(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] em, input logic [3:0] et,
                               input logic [3:0] eu, input logic emag, input logic edone);
        compared++;
        assert ({minutes, tens_sec, units_sec, magnetron_on, done} === {em, et, eu, emag, edone})
        else begin
            mismatched++;
            $error("[TB] FAIL %s: got %0d:%0d%0d mag=%0b done=%0b, expected %0d:%0d%0d mag=%0b done=%0b",
                   tag, minutes, tens_sec, units_sec, magnetron_on, done, em, et, eu, emag, edone);
        end
    endtask

    initial begin
        reset_n = 1'b1;
        #3 reset_n = 1'b0;
        #2;
        checkOutput("reset_state", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;

        key(4'd1);
        checkOutput("entry_1", 4'd0, 4'd0, 4'd1, 1'b0, 1'b0);
        key(4'd3);
        key(4'd0);
        checkOutput("entry_130", 4'd1, 4'd3, 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("start_130", 4'd1, 4'd3, 4'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("tick_129", 4'd1, 4'd2, 4'd9, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("clear_cook", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);

        key(4'd1); key(4'd0); key(4'd0);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("tick_059", 4'd0, 4'd5, 4'd9, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);

        key(4'd1);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("start_001", 4'd0, 4'd0, 4'd1, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("reach_done", 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("done_tick1", 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("done_tick2", 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("done_timeout", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);

        key(4'd0); key(4'd7);
        checkOutput("entry_007", 4'd0, 4'd0, 4'd7, 1'b0, 1'b0);
        key(4'd8);
        checkOutput("units_gt5_ignored", 4'd0, 4'd0, 4'd7, 1'b0, 1'b0);
        key(4'd12);
        checkOutput("key12_after_7", 4'd0, 4'd0, 4'd7, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        key(4'd12);
        checkOutput("key12_ignored", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        key(4'd5);
        checkOutput("entry_005", 4'd0, 4'd0, 4'd5, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("idle_stop_zero", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);

        key(4'd4); key(4'd5);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("start_045", 4'd0, 4'd4, 4'd5, 1'b1, 1'b0);
        door_closed = 1'b0;
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("door_open_pause", 4'd0, 4'd4, 4'd5, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("pause_tick_frozen", 4'd0, 4'd4, 4'd5, 1'b0, 1'b0);
        door_closed = 1'b1;
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("resume_045", 4'd0, 4'd4, 4'd5, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("resume_tick_044", 4'd0, 4'd4, 4'd4, 1'b1, 1'b0);

        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("start_zero_ignored", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        key(4'd2);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("start_002", 4'd0, 4'd0, 4'd2, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("start_stop_pause", 4'd0, 4'd0, 4'd2, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("clear_pause", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("clear_went_idle", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);

        key(4'd1);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("done_again", 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("done_start_exit", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);

        key(4'd2); key(4'd1); key(4'd5);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("start_215", 4'd2, 4'd1, 4'd5, 1'b1, 1'b0);
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("async_reset_midcook", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("post_reset_idle", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/microwave_timer_ctrl.md
MICROWAVE_TIMER_CTRL -- requirements
Module: microwave_timer_ctrl

Interface
REQ-001 SHALL have parameter DONE_TICKS, default 3, number of sec_tick pulses the done indication is held.
REQ-002 SHALL have ports, one per line:
- clock  input  1  sole clock; all state changes on its rising edge
- reset_n  input  1  asynchronous, active-low reset
- keypad_valid  input  1  one-cycle strobe; keypad_digit valid
- keypad_digit  input  4  BCD digit entered
- start  input  1  one-cycle start/resume request
- stop  input  1  one-cycle stop request
- clear  input  1  one-cycle clear request
- door_closed  input  1  1 = door closed
- sec_tick  input  1  one-cycle pulse, once per second
- units_sec  output  4  BCD seconds units, feeds 7-segment decoder
- tens_sec  output  4  BCD seconds tens, range 0-5
- minutes  output  4  BCD minutes, range 0-9
- magnetron_on  output  1  heating enable
- done  output  1  cook-complete indication
REQ-003 SHALL use one clock; reset SHALL be asynchronous and active-low.

Function
REQ-004 SHALL implement FSM states IDLE, COOK, PAUSE, DONE; all outputs registered.
REQ-005 Event priority per cycle SHALL be: clear > stop > door open > start > sec_tick > keypad entry.
REQ-006 clear in any state SHALL go to IDLE and zero all three digits on the next edge.
REQ-007 IDLE, keypad_valid with digit <= 9 SHALL shift left: minutes <= tens_sec, tens_sec <= units_sec, units_sec <= keypad_digit.
REQ-008 IDLE, keypad entry SHALL be ignored if keypad_digit > 9 or current units_sec > 5 (keeps tens_sec <= 5); minutes' old value is discarded on shift.
REQ-009 IDLE, stop SHALL zero the digits.
REQ-010 IDLE, start with door_closed = 1 and time != 0:00 SHALL enter COOK next edge; otherwise start is ignored.
REQ-011 COOK: magnetron_on SHALL be 1; in all other states 0.
REQ-012 COOK, sec_tick SHALL decrement BCD time: units 0 -> 9 with borrow from tens; tens 0 -> 5 with borrow from minutes.
REQ-013 COOK, decrement reaching 0:00 SHALL enter DONE on the same edge; magnetron_on low the following cycle.
REQ-014 COOK, door_closed = 0 or stop SHALL enter PAUSE with no decrement that cycle, even if sec_tick is asserted.
REQ-015 PAUSE: digits frozen, sec_tick ignored; start with door_closed = 1 SHALL return to COOK; stop SHALL go to IDLE with digits zeroed.
REQ-016 DONE: done = 1, digits 0:00; after DONE_TICKS sec_tick pulses SHALL go to IDLE; start or stop SHALL go to IDLE immediately.
REQ-017 keypad entry SHALL be ignored outside IDLE.
REQ-018 Simultaneous start and stop SHALL act as stop.

Reset
REQ-019 reset_n low SHALL immediately force IDLE, digits 0:00, magnetron_on = 0, done = 0, done tick counter 0, including mid-cook.
REQ-020 After reset_n deasserts, first state change SHALL occur on the next rising clock edge.

Verification
REQ-021 Keys 1,3,0 then start, door closed -> display 1:30, magnetron_on = 1; next sec_tick -> 1:29.
REQ-022 Cook from 1:00, one sec_tick -> 0:59; from 0:01, one sec_tick -> 0:00, DONE, done = 1; after 3 ticks -> IDLE, done = 0.
REQ-023 Keys 0,7 then 8 -> entry of 8 ignored (units 7 > 5), display stays 0:07; key 12 ignored.
REQ-024 COOK at 0:45, door_closed falls with sec_tick in same cycle -> PAUSE at 0:45, magnetron_on = 0; door closes plus start -> COOK resumes from 0:45.
REQ-025 start with 0:00 -> remains IDLE; start and stop together in COOK -> PAUSE; clear in PAUSE -> IDLE, 0:00.
REQ-026 reset_n asserted mid-COOK at 2:15 -> outputs 0:00, magnetron_on = 0 without waiting for clock edge.
